sobel_stream_engine: RTL and testbench
======================================

// Module: sobel_stream_engine
// PURPOSE
//  Parametrised streaming 3x3 Sobel engine that replaces the address-driven gray/Sobel memory op.
//  Accepts a raster-order grayscale frame over a valid/ready input and keeps two line buffers internally.
//  Emits one result per pixel position with the linear write address, the signed Gx/Gy and a mode-selected magnitude.
//  Sits between grayScale and the Gx/Gy/result memories; frame_done drives the top-level FSM.
// PARAMETERS
//  IMG_W   32  pixels per line (>=3)
//  IMG_H   32  lines per frame (>=3)
//  PIX_W   4   grayscale input pixel width
//  ADDR_W  10  output address width (>= clog2(IMG_W*IMG_H))
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          asynchronous, active-low reset
//  start      in   1          one-cycle pulse; begins a frame when idle
//  mode       in   2          0:|Gx|+|Gy| sat, 1:|Gx| sat, 2:|Gy| sat, 3:threshold
//  thresh     in   PIX_W+3    threshold for mode 3, compared with |Gx|+|Gy|
//  in_valid   in   1          in_pix is valid
//  in_pix     in   PIX_W      grayscale pixel, raster order
//  in_ready   out  1          engine accepts in_pix this cycle
//  out_valid  out  1          result valid (no backpressure)
//  out_addr   out  ADDR_W     linear index cy*IMG_W+cx of the result centre
//  out_gx     out  PIX_W+4    signed Gx
//  out_gy     out  PIX_W+4    signed Gy
//  out_mag    out  PIX_W      magnitude per mode
//  busy       out  1          high from accepted start until frame_done
//  frame_done out  1          one-cycle pulse after the last result
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all outputs 0; counters 0; line buffers need not be cleared.
//  FSM: IDLE -start-> RUN -> (IMG_W*IMG_H pixels accepted) -> FLUSH -> (IMG_W+1 cycles) -> DONE -> IDLE.
//  IDLE: in_ready=0, busy=0. start is ignored outside IDLE.
//  RUN: in_ready=1, and a pixel is accepted when in_valid&in_ready. in_valid gaps stall the pipeline and lose no data.
//  FLUSH: in_ready=0. The engine injects one zero pixel per cycle, with no input needed.
//  DONE: single cycle; frame_done=1 and busy drops to 0 in the same cycle.
//  Pipeline: accepting (real or flush) stream pixel p>=IMG_W+1 produces the result for centre k=p-IMG_W-1.
//    That result is registered, so out_valid is high the following cycle. Exactly IMG_W*IMG_H results are
//    produced, with out_addr strictly 0,1,...,IMG_W*IMG_H-1.
//  Window (centre cx,cy): a=top row, c=bottom row; columns L,M,R.
//    Gx = (aR+2mR+cR)-(aL+2mL+cL); Gy = (cL+2cM+cR)-(aL+2aM+aR). Both are two's complement PIX_W+4 bits.
//  Border: if cx==0, cx==IMG_W-1, cy==0 or cy==IMG_H-1, then out_gx=out_gy=out_mag=0. Out-of-frame taps never reach a result.
//  Magnitude: S=|Gx|+|Gy| (PIX_W+3 bits). Modes 0-2 saturate to 2^PIX_W-1.
//    Mode 3: out_mag = all-ones if S>=thresh, else 0.
//  mode and thresh are sampled at accepted start and held for the whole frame.
//  Column wrap: the engine tracks the raster column. A window never mixes pixels from line end and next line start.
//  frame_done asserts exactly 1 cycle after the out_valid carrying the last address.
//  Reset mid-frame aborts immediately. The next start after reset processes a full fresh frame.
// TESTING
//  Bench overrides IMG_W=IMG_H=4, PIX_W=4.
//  T1 flat image all 7, mode 0 -> 16 out_valid, addr 0..15, gx=gy=mag=0; frame_done 1 cycle after addr 15.
//  T2 columns 0,1=0 and 2,3=15, mode 0 -> addr 5 and 9: gx=+60, gy=0, mag=15 (sat); mode 1 same; mode 2 mag=0.
//  T3 rows 0,1=0 and 2,3=3, mode 3, thresh=12 -> addr 5,6,9,10: gy=+12, mag=15; thresh=13 -> mag=0.
//  T4 T2 image with in_valid toggling every other cycle -> identical 16 results in order; in_ready=0 during the 5 flush cycles.
//  T5 rst=0 asserted after 9 pixels -> all outputs 0 asynchronously; new start + T1 image -> clean 16 results.
//  T6 start re-pulsed during RUN with mode changed -> ignored; results keep the original mode, 16 results, one frame_done.

Source files
------------

// File: rtl/sobel_stream_engine.sv
// sobel_stream_engine: streaming 3x3 Sobel over a raster grayscale frame.
// Rev 1.0 - two-line delay buffer, registered Gx/Gy/magnitude per pixel position.
`default_nettype none

module sobel_stream_engine #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int PIX_W  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [PIX_W+2:0]  thresh_i,
  input  logic              in_valid_i,
  input  logic [PIX_W-1:0]  in_pix_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [PIX_W+3:0]  out_gx_o,
  output logic [PIX_W+3:0]  out_gy_o,
  output logic [PIX_W-1:0]  out_mag_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int NPIX    = IMG_W * IMG_H;
  localparam int NSTREAM = NPIX + IMG_W + 1;
  localparam int CNT_W   = $clog2(NSTREAM + 1);
  localparam int XW      = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int YW      = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int DEPTH   = 2 * IMG_W + 2;
  localparam int SW      = PIX_W + 2;
  localparam int GW      = PIX_W + 4;

  localparam logic [CNT_W-1:0] C_LAST_IN  = CNT_W'(NPIX - 1);
  localparam logic [CNT_W-1:0] C_LAST_STR = CNT_W'(NSTREAM - 1);
  localparam logic [CNT_W-1:0] C_FIRST_RS = CNT_W'(IMG_W + 1);
  localparam logic [XW-1:0]    C_XMAX     = XW'(IMG_W - 1);
  localparam logic [YW-1:0]    C_YMAX     = YW'(IMG_H - 1);
  localparam logic [GW-1:0]    C_PIXMAX   = GW'((1 << PIX_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XW-1:0]       cx_q;
  logic [YW-1:0]       cy_q;
  logic [1:0]          mode_q;
  logic [PIX_W+2:0]    thresh_q;
  logic                out_valid_q, busy_q, frame_done_q;
  logic [ADDR_W-1:0]   out_addr_q;
  logic [GW-1:0]       out_gx_q, out_gy_q;
  logic [PIX_W-1:0]    out_mag_q;
  logic [PIX_W-1:0]    line_q [DEPTH];

  logic                w_start, w_accept, w_produce, w_border;
  logic [PIX_W-1:0]    w_pix;
  logic [SW-1:0]       w_sum_l, w_sum_r, w_sum_t, w_sum_b;
  logic [GW-1:0]       w_gx, w_gy, w_ax, w_ay, w_s;
  logic [PIX_W-1:0]    w_mag;

  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    w_accept   = 1'b0;
    w_pix      = '0;
    w_start    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          w_start = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        in_ready_o = 1'b1;
        w_accept   = in_valid_i;
        w_pix      = in_pix_i;
        if (in_valid_i && cnt_q == C_LAST_IN) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        w_accept = 1'b1;
        if (cnt_q == C_LAST_STR) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Index j holds stream pixel p-1-j; the incoming pixel is the bottom-right tap.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      line_q[0] <= w_pix;
      for (int i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  always_comb begin
    w_sum_r = SW'(line_q[2*IMG_W-1]) + (SW'(line_q[IMG_W-1]) << 1) + SW'(w_pix);
    w_sum_l = SW'(line_q[2*IMG_W+1]) + (SW'(line_q[IMG_W+1]) << 1) + SW'(line_q[1]);
    w_sum_b = SW'(line_q[1]) + (SW'(line_q[0]) << 1) + SW'(w_pix);
    w_sum_t = SW'(line_q[2*IMG_W+1]) + (SW'(line_q[2*IMG_W]) << 1) + SW'(line_q[2*IMG_W-1]);
    w_gx    = GW'(w_sum_r) - GW'(w_sum_l);
    w_gy    = GW'(w_sum_b) - GW'(w_sum_t);
    w_ax    = w_gx[GW-1] ? (~w_gx + GW'(1)) : w_gx;
    w_ay    = w_gy[GW-1] ? (~w_gy + GW'(1)) : w_gy;
    w_s     = w_ax + w_ay;
    w_mag   = '0;
    case (mode_q)
      2'd0:    w_mag = (w_s  > C_PIXMAX) ? '1 : w_s[PIX_W-1:0];
      2'd1:    w_mag = (w_ax > C_PIXMAX) ? '1 : w_ax[PIX_W-1:0];
      2'd2:    w_mag = (w_ay > C_PIXMAX) ? '1 : w_ay[PIX_W-1:0];
      default: w_mag = (w_s >= GW'(thresh_q)) ? '1 : '0;
    endcase
    // Border centres are the only ones whose taps wrap across lines or leave the frame.
    w_border  = (cx_q == '0) || (cx_q == C_XMAX) || (cy_q == '0) || (cy_q == C_YMAX);
    w_produce = w_accept && (cnt_q >= C_FIRST_RS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      mode_q       <= '0;
      thresh_q     <= '0;
      out_valid_q  <= 1'b0;
      out_addr_q   <= '0;
      out_gx_q     <= '0;
      out_gy_q     <= '0;
      out_mag_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != S_IDLE);
      frame_done_q <= (state_q == S_DONE);
      out_valid_q  <= w_produce;
      if (w_start) begin
        cnt_q    <= '0;
        addr_q   <= '0;
        cx_q     <= '0;
        cy_q     <= '0;
        mode_q   <= mode_i;
        thresh_q <= thresh_i;
      end
      if (w_accept) cnt_q <= cnt_q + CNT_W'(1);
      if (w_produce) begin
        out_addr_q <= addr_q;
        out_gx_q   <= w_border ? '0 : w_gx;
        out_gy_q   <= w_border ? '0 : w_gy;
        out_mag_q  <= w_border ? '0 : w_mag;
        addr_q     <= addr_q + ADDR_W'(1);
        if (cx_q == C_XMAX) begin
          cx_q <= '0;
          cy_q <= cy_q + YW'(1);
        end else begin
          cx_q <= cx_q + XW'(1);
        end
      end
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_addr_o   = out_addr_q;
  assign out_gx_o     = out_gx_q;
  assign out_gy_o     = out_gy_q;
  assign out_mag_o    = out_mag_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_sobel_stream_engine.sv
// tb_sobel_stream_engine: directed frames on a 4x4 Sobel engine with a reference window model.
// Rev 1.0
`default_nettype none

module tb_sobel_stream_engine;

  localparam int W = 4;
  localparam int H = 4;
  localparam int P = 4;
  localparam int A = 10;
  localparam int N = W * H;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   mode = '0;
  logic [P+2:0] thresh = '0;
  logic         in_valid = 1'b0;
  logic [P-1:0] in_pix = '0;
  logic         in_ready, out_valid, busy, frame_done;
  logic [A-1:0] out_addr;
  logic [P+3:0] out_gx, out_gy;
  logic [P-1:0] out_mag;

  sobel_stream_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(P), .ADDR_W(A)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .thresh_i(thresh),
    .in_valid_i(in_valid), .in_pix_i(in_pix), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_addr_o(out_addr), .out_gx_o(out_gx), .out_gy_o(out_gy),
    .out_mag_o(out_mag), .busy_o(busy), .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int cyc = 0, n_res = 0, n_done = 0, last_v_cyc = -1, done_cyc = -1;
  int r_addr [512];
  int r_gx   [512];
  int r_gy   [512];
  int r_mag  [512];

  always @(negedge clk) begin
    cyc++;
    if (out_valid) begin
      if (n_res < 512) begin
        r_addr[n_res] = int'(out_addr);
        r_gx[n_res]   = int'($signed(out_gx));
        r_gy[n_res]   = int'($signed(out_gy));
        r_mag[n_res]  = int'(out_mag);
      end
      n_res++;
      last_v_cyc = cyc;
    end
    if (frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  logic [P-1:0] img [N];

  task automatic set_img(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       img[i] = 4'd7;
        1:       img[i] = ((i % W) >= 2) ? 4'd15 : 4'd0;
        default: img[i] = ((i / W) >= 2) ? 4'd3 : 4'd0;
      endcase
    end
  endtask

  function automatic int px(input int x, input int y);
    return int'(img[y*W + x]);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model(input int k, input int md, input int thr,
                       output int gx, output int gy, output int mag);
    int cx, cy, s;
    cx = k % W; cy = k / W;
    gx = 0; gy = 0; mag = 0;
    if (cx != 0 && cx != W-1 && cy != 0 && cy != H-1) begin
      gx = (px(cx+1, cy-1) + 2*px(cx+1, cy) + px(cx+1, cy+1))
         - (px(cx-1, cy-1) + 2*px(cx-1, cy) + px(cx-1, cy+1));
      gy = (px(cx-1, cy+1) + 2*px(cx, cy+1) + px(cx+1, cy+1))
         - (px(cx-1, cy-1) + 2*px(cx, cy-1) + px(cx+1, cy-1));
      s = iabs(gx) + iabs(gy);
      case (md)
        0:       mag = sat(s);
        1:       mag = sat(iabs(gx));
        2:       mag = sat(iabs(gy));
        default: mag = (s >= thr) ? 15 : 0;
      endcase
    end
  endtask

  task automatic run_frame(input int md, input int thr, input bit gaps, input bit repulse,
                           output int base);
    int b_done, nz, gx, gy, mag;
    base = n_res; b_done = n_done;
    @(posedge clk); #1;
    start = 1'b1; mode = 2'(md); thresh = 7'(thr);
    @(posedge clk); #1;
    start = 1'b0; mode = 2'(md + 1); thresh = 7'(thr + 5);
    check("busy_run", int'(busy), 1);
    check("ready_run", int'(in_ready), 1);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (repulse && i == 5) begin
        start = 1'b1;
        mode  = 2'(md + 2);
      end
      in_valid = 1'b1;
      in_pix   = img[i];
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    nz = 0;
    for (int j = 0; j < W + 1; j++) begin
      @(negedge clk);
      if (!in_ready) nz++;
    end
    check("ready_flush_low", nz, W + 1);
    for (int c = 0; c < 100 && n_done == b_done; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("frame_done_cnt", n_done - b_done, 1);
    check("result_cnt", n_res - base, N);
    check("done_latency", done_cyc - last_v_cyc, 1);
    check("busy_after", int'(busy), 0);
    for (int i = 0; i < N; i++) begin
      model(i, md, thr, gx, gy, mag);
      check($sformatf("addr[%0d]", i), r_addr[base+i], i);
      check($sformatf("gx[%0d]", i),   r_gx[base+i],   gx);
      check($sformatf("gy[%0d]", i),   r_gy[base+i],   gy);
      check($sformatf("mag[%0d]", i),  r_mag[base+i],  mag);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_ready"}, int'(in_ready), 0);
    check({tag, "_done"},  int'(frame_done), 0);
    check({tag, "_addr"},  int'(out_addr), 0);
    check({tag, "_gx"},    int'(out_gx), 0);
    check({tag, "_mag"},   int'(out_mag), 0);
  endtask

  initial begin
    int b;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst_n = 1'b1;

    // T1 flat image
    set_img(0);
    run_frame(0, 0, 1'b0, 1'b0, b);

    // T2 vertical edge, three magnitude modes
    set_img(1);
    run_frame(0, 0, 1'b0, 1'b0, b);
    check("T2_gx5", r_gx[b+5], 60);
    check("T2_gy5", r_gy[b+5], 0);
    check("T2_mag5", r_mag[b+5], 15);
    check("T2_gx9", r_gx[b+9], 60);
    run_frame(1, 0, 1'b0, 1'b0, b);
    check("T2m1_mag9", r_mag[b+9], 15);
    run_frame(2, 0, 1'b0, 1'b0, b);
    check("T2m2_mag5", r_mag[b+5], 0);

    // T3 horizontal edge, threshold boundary
    set_img(2);
    run_frame(3, 12, 1'b0, 1'b0, b);
    check("T3_gy6", r_gy[b+6], 12);
    check("T3_mag10", r_mag[b+10], 15);
    run_frame(3, 13, 1'b0, 1'b0, b);
    check("T3_mag5_t13", r_mag[b+5], 0);

    // T4 input gaps
    set_img(1);
    run_frame(0, 0, 1'b1, 1'b0, b);

    // T5 asynchronous reset mid-frame
    set_img(0);
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_pix   = img[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("T5_pre_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_zero("T5_async");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame(0, 0, 1'b0, 1'b0, b);

    // T6 start ignored during RUN
    set_img(1);
    run_frame(0, 0, 1'b0, 1'b1, b);
    check("T6_mag5", r_mag[b+5], 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
